// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   XLEN  : operand width; the product is 2*XLEN bits
//   CNTW  : width of the iteration down-counter (holds XLEN down to 1)
//   state_t : controller states
package mult_pkg;
    localparam int XLEN = 32;
    localparam int CNTW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_booth_if.sv
// Handshake and result bundle between the control unit and the multiplier.
//   start      : one-cycle multiply request (master -> slave)
//   a, b       : signed multiplicand / multiplier (master -> slave)
//   busy, done : status; done pulses for one cycle per completed product
//   hi, lo     : upper / lower halves of the last completed product
interface mult_booth_if #(parameter int WIDTH = mult_pkg::XLEN);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, a, b, input busy, done, hi, lo);
    modport slave  (input start, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
//   acc, q, q_m1, m          : current accumulator (W+1), multiplier, guard bit, multiplicand (W+1)
//   acc_nx, q_nx, q_m1_nx    : state after the add/subtract and arithmetic right shift
module booth_step #(parameter int W = 32) (
    input  logic [W:0]   acc,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W:0]   m,
    output logic [W:0]   acc_nx,
    output logic [W-1:0] q_nx,
    output logic         q_m1_nx
);
    logic [W:0] sum;

    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b10:   sum = acc - m;
            2'b01:   sum = acc + m;
            default: sum = acc;
        endcase
    end

    // Shift {sum, q, q_m1} right by one, replicating the accumulator sign bit.
    assign acc_nx  = {sum[W], sum[W:1]};
    assign q_nx    = {sum[0], q[W-1:1]};
    assign q_m1_nx = q[0];
endmodule

// File: rtl/mult_booth.sv
// Sequential radix-2 Booth multiplier, XLEN x XLEN signed -> 2*XLEN.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of mult_booth_if (start/a/b in, busy/done/hi/lo out)
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one Booth iteration per edge, count runs XLEN down to 1
//   DONE  | product valid in hi/lo, done high for this one cycle
module mult_booth
    import mult_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mult_booth_if.slave  bus
);
    state_t state, state_nx;

    logic [XLEN:0]   acc, m;
    logic [XLEN-1:0] q;
    logic            q_m1;
    logic [CNTW-1:0] count;
    logic [XLEN-1:0] hi, lo;

    logic [XLEN:0]   acc_nx;
    logic [XLEN-1:0] q_nx;
    logic            q_m1_nx;

    logic accept, last_iter;

    booth_step #(.W(XLEN)) u_step (
        .acc     (acc),
        .q       (q),
        .q_m1    (q_m1),
        .m       (m),
        .acc_nx  (acc_nx),
        .q_nx    (q_nx),
        .q_m1_nx (q_m1_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (count == CNTW'(1)) begin
                    last_iter = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            m     <= {bus.a[XLEN-1], bus.a};
            acc   <= '0;
            q     <= bus.b;
            q_m1  <= 1'b0;
            count <= CNTW'(XLEN);
        end else if (state == RUN) begin
            acc   <= acc_nx;
            q     <= q_nx;
            q_m1  <= q_m1_nx;
            count <= count - CNTW'(1);
            // The accumulator's extra sign bit is dropped from the product.
            if (last_iter) begin
                hi <= acc_nx[XLEN-1:0];
                lo <= q_nx;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;
    import mult_pkg::*;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mult_booth_if #(.WIDTH(XLEN)) mif ();

    mult_booth dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    // One full operation; if pulse_at > 0 a second start is offered at that edge.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input int pulse_at, input string tag);
        logic [63:0] e;
        int  n;
        bit  seen;
        bit  busy_ok;
        e       = model(av, bv);
        n       = 0;
        seen    = 0;
        busy_ok = 1;
        @(negedge clk);
        mif.start = 1'b1;
        mif.a     = av;
        mif.b     = bv;
        @(posedge clk);
        #1;
        check({tag, "_busy_e0"}, 64'(mif.busy), 64'd1);
        @(negedge clk);
        mif.start = 1'b0;
        mif.a     = $urandom;
        mif.b     = $urandom;
        while (!seen && n < 40) begin
            if (n + 1 == pulse_at) begin
                mif.start = 1'b1;
                mif.a     = 32'd9;
                mif.b     = 32'd9;
            end
            @(posedge clk);
            n++;
            #1;
            if (mif.done) seen = 1;
            else if (!mif.busy) busy_ok = 0;
            @(negedge clk);
            mif.start = 1'b0;
        end
        check({tag, "_done_edge"}, 64'(n), 64'd32);
        check({tag, "_busy_held"}, 64'(busy_ok), 64'd1);
        check({tag, "_hi"}, 64'(mif.hi), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(mif.lo), 64'(e[31:0]));
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 64'(mif.done), 64'd0);
        check({tag, "_busy_fall"}, 64'(mif.busy), 64'd0);
        check({tag, "_hold"}, {mif.hi, mif.lo}, e);
    endtask

    initial begin
        logic [31:0] corner [6];
        int accepts [$];
        int cyc, ndone;
        bit prev_busy, prev_done, dbl;
        logic [63:0] e;

        corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h0000_0000; corner[4] = 32'h0000_0001; corner[5] = 32'h8000_0001;

        mif.start = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        reset     = 1'b0;
        #23;
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_done", 64'(mif.done), 64'd0);
        check("rst_hi", 64'(mif.hi), 64'd0);
        check("rst_lo", 64'(mif.lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(32'd7, 32'hFFFF_FFFD, 0, "neg3");
        run_op(32'h8000_0000, 32'h8000_0000, 0, "minmin");
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "maxmax");
        run_op(32'h0, 32'h1234_5678, 0, "zero");
        run_op(32'd5, 32'd6, 10, "ignore_start");

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        mif.start = 1'b1; mif.a = 32'd3; mif.b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(mif.busy), 64'd0);
        check("abort_done", 64'(mif.done), 64'd0);
        check("abort_hilo", {mif.hi, mif.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (mif.done || mif.busy) ndone++;
        end
        check("abort_quiet", 64'(ndone), 64'd0);
        run_op(32'd2, 32'hFFFF_FFFE, 0, "after_abort");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = (i % 3 == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = (i % 4 == 1) ? corner[$urandom_range(0, 5)] : $urandom;
            run_op(ra, rb, (i % 2 == 0) ? int'($urandom_range(1, 33)) : 0, $sformatf("rnd%0d", i));
        end

        // Back-to-back operations with start held high.
        e = model(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        mif.start = 1'b1; mif.a = 32'hFFFF_FFFF; mif.b = 32'hFFFF_FFFF;
        cyc = 0; ndone = 0; prev_busy = 0; prev_done = 0; dbl = 0;
        repeat (120) begin
            @(posedge clk);
            cyc++;
            #1;
            if (mif.busy && !prev_busy) accepts.push_back(cyc);
            if (mif.done) begin
                ndone++;
                if (prev_done) dbl = 1;
                check($sformatf("held_prod%0d", ndone), {mif.hi, mif.lo}, e);
            end
            prev_busy = mif.busy;
            prev_done = mif.done;
        end
        mif.start = 1'b0;
        check("held_accepts", 64'(accepts.size()), 64'd4);
        for (int i = 1; i < accepts.size(); i++)
            check($sformatf("held_period%0d", i), 64'(accepts[i] - accepts[i-1]), 64'd34);
        check("held_done_cnt", 64'(ndone), 64'd3);
        check("held_done_width", 64'(dbl), 64'd0);
        cyc = 0;
        while (mif.busy && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("held_drain", 64'(mif.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
